fetch_prefetch_q: RTL and testbench

- Parametrised next-generation instruction fetch stage for the MIPS R2000 pipeline.
- Owns the fetch PC and drives a request/grant/response instruction-memory port, with one request in flight.
- Buffers returned words in a DEPTH-entry prefetch queue; the decode stage drains it under `hold_if`.
- Branch or exception redirect flushes the queue and discards any stale in-flight response.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_prefetch_q_if.sv | 30 +++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_prefetch_q.sv | 121 ++++++++++++
 tb/tb_fetch_prefetch_q.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The prefetch queue entry carries the sequential PC and the fetched word.
package fetch_pkg;

    localparam int unsigned INST_STEP = 4;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h4000_0040;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_q_if.sv
// Instruction-memory request/grant/response port.
// The fetch stage is the master; the memory side is the slave.
interface fetch_prefetch_q_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular prefetch buffer with synchronous reset and flush.
// The head reads as zero while the buffer is empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output T              head
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_push = push && !flush && !rst;
    assign w_pop  = pop && (r_cnt != '0) && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + AW'(1);
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= din;
    end

    assign count = r_cnt;
    assign head  = (r_cnt != '0) ? r_mem[r_rd] : T'('0);

endmodule

// File: rtl/fetch_prefetch_q.sv
// Fetch stage: owns the fetch PC, issues one-in-flight imem requests
// and buffers responses in a prefetch queue drained by decode.
module fetch_prefetch_q
    import fetch_pkg::*;
#(
    parameter int          DATA_W       = 32,
    parameter int          ADDR_W       = 32,
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                br,
    input  logic [ADDR_W-1:0]   pc_branch,
    input  logic                except,
    input  logic                hold_if,
    fetch_prefetch_q_if.master  imem,
    output logic                valid_out,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [DATA_W-1:0]   inst_out
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc4;
        logic [DATA_W-1:0] inst;
    } entry_t;

    logic [ADDR_W-1:0] r_fpc;
    logic [ADDR_W-1:0] r_oaddr;
    logic              r_out;
    logic              r_drop;

    logic              w_redir;
    logic [ADDR_W-1:0] w_target;
    logic [CW-1:0]     w_count;
    logic [CW:0]       w_used;
    logic              w_slot;
    logic              w_req;
    logic              w_gnt;
    logic              w_push;
    logic              w_pop;
    logic              w_keep;
    entry_t            w_din;
    entry_t            w_head;

    assign w_redir  = except | br;
    assign w_target = except ? ADDR_W'(EXC_VECTOR)
                             : (pc_branch & ~ADDR_W'(3));

    // Outstanding request already owns a queue slot.
    assign w_used = {1'b0, w_count} + {{CW{1'b0}}, r_out};
    assign w_slot = w_used < (CW+1)'(DEPTH);

    assign w_req = !rst && !w_redir && w_slot
                && (!r_out || (imem.imem_rvalid && !r_drop));
    assign w_gnt = w_req && imem.imem_gnt;

    assign w_push = !rst && !w_redir && r_out && !r_drop
                 && imem.imem_rvalid;
    assign w_pop  = valid_out && !hold_if;

    // A request still waiting for its response survives reset/redirect
    // as a stale transfer so its late response is swallowed.
    assign w_keep = r_out && !imem.imem_rvalid;

    assign w_din.pc4  = r_oaddr + ADDR_W'(INST_STEP);
    assign w_din.inst = imem.imem_rdata;

    always_ff @(posedge clk) begin
        if (rst || w_redir) begin
            r_fpc   <= rst ? ADDR_W'(RESET_VECTOR) : w_target;
            r_out   <= w_keep;
            r_drop  <= w_keep;
            if (rst)
                r_oaddr <= '0;
        end else begin
            if (w_gnt) begin
                r_oaddr <= r_fpc;
                r_fpc   <= r_fpc + ADDR_W'(INST_STEP);
                r_out   <= 1'b1;
            end else if (imem.imem_rvalid) begin
                r_out   <= 1'b0;
            end
            if (imem.imem_rvalid)
                r_drop <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_din),
        .pop   (w_pop),
        .flush (w_redir),
        .count (w_count),
        .head  (w_head)
    );

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_fpc;

    assign valid_out = (w_count != '0);
    assign pc_out    = w_head.pc4;
    assign inst_out  = w_head.inst;

    a_rsp_has_req: assert property (
        @(posedge clk) imem.imem_rvalid |-> r_out
    );

    a_no_overflow: assert property (
        @(posedge clk) w_push |-> (w_count < CW'(DEPTH))
    );

endmodule

// File: tb/tb_fetch_prefetch_q.sv
// Directed bench for fetch_prefetch_q with a fixed-latency memory model.
// Memory returns addr ^ 32'hDEAD_0000 for every granted request.
module tb_fetch_prefetch_q;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br = 1'b0;
    logic        except = 1'b0;
    logic        hold_if = 1'b0;
    logic [31:0] pc_branch = '0;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;

    int          n_chk = 0;
    int          n_fail = 0;
    int          lat = 1;
    logic        p_valid = 1'b0;
    int          p_cnt = 0;
    logic [31:0] p_addr = '0;

    fetch_prefetch_q_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    fetch_prefetch_q dut (
        .clk       (clk),
        .rst       (rst),
        .br        (br),
        .pc_branch (pc_branch),
        .except    (except),
        .hold_if   (hold_if),
        .imem      (bus),
        .valid_out (valid_out),
        .pc_out    (pc_out),
        .inst_out  (inst_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample the handshake, advance, update the memory model.
    task automatic step();
        logic        fire;
        logic [31:0] a;
        #1;
        fire = bus.imem_req && bus.imem_gnt;
        a    = bus.imem_addr;
        @(posedge clk);
        #1;
        bus.imem_rvalid = 1'b0;
        if (fire) begin
            p_valid = 1'b1;
            p_addr  = a;
            p_cnt   = lat;
        end
        if (p_valid) begin
            p_cnt--;
            if (p_cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = p_addr ^ 32'hDEAD_0000;
                p_valid         = 1'b0;
            end
        end
        #1;
    endtask

    task automatic quiesce_reset(input int new_lat);
        bus.imem_gnt = 1'b0;
        hold_if = 1'b0;
        for (int i = 0; i < 5; i++) step();
        lat = new_lat;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        // Reset state
        step();
        step();
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_req", 64'(bus.imem_req), 64'd0);
        check("rst_pc", 64'(pc_out), 64'd0);
        check("rst_inst", 64'(inst_out), 64'd0);
        rst = 1'b0;
        #1;

        // Free run, latency 1
        check("run_req0", 64'(bus.imem_req), 64'd1);
        check("run_addr0", 64'(bus.imem_addr), 64'h0);
        step();
        check("run_addr1", 64'(bus.imem_addr), 64'h4);
        check("run_valid1", 64'(valid_out), 64'd0);
        step();
        check("run_valid2", 64'(valid_out), 64'd1);
        check("run_pc2", 64'(pc_out), 64'h4);
        check("run_inst2", 64'(inst_out), 64'hDEAD_0000);
        check("run_addr2", 64'(bus.imem_addr), 64'h8);
        step();
        check("run_pc3", 64'(pc_out), 64'h8);
        check("run_inst3", 64'(inst_out), 64'hDEAD_0004);
        step();
        check("run_pc4", 64'(pc_out), 64'hC);
        check("run_inst4", 64'(inst_out), 64'hDEAD_0008);

        // Hold decode until the queue fills
        hold_if = 1'b1;
        step();
        step();
        check("hold_req6", 64'(bus.imem_req), 64'd0);
        step();
        check("hold_req7", 64'(bus.imem_req), 64'd0);
        check("hold_pc7", 64'(pc_out), 64'hC);
        hold_if = 1'b0;
        #1;
        step();
        check("drain_pc8", 64'(pc_out), 64'h10);
        check("drain_req8", 64'(bus.imem_req), 64'd1);
        check("drain_addr8", 64'(bus.imem_addr), 64'h18);
        step();
        check("drain_pc9", 64'(pc_out), 64'h14);
        step();
        check("drain_pc10", 64'(pc_out), 64'h18);
        check("drain_inst10", 64'(inst_out), 64'hDEAD_0014);
        step();
        check("drain_pc11", 64'(pc_out), 64'h1C);
        check("drain_inst11", 64'(inst_out), 64'hDEAD_0018);

        // Branch while a latency-3 request is outstanding
        quiesce_reset(3);
        bus.imem_gnt = 1'b1;
        #1;
        check("br_addr0", 64'(bus.imem_addr), 64'h0);
        step();
        br = 1'b1;
        pc_branch = 32'h0000_0103;
        #1;
        check("br_req_redir", 64'(bus.imem_req), 64'd0);
        step();
        br = 1'b0;
        #1;
        check("br_req_drop", 64'(bus.imem_req), 64'd0);
        step();
        check("br_stale_rv", 64'(bus.imem_rvalid), 64'd1);
        check("br_req_stale", 64'(bus.imem_req), 64'd0);
        check("br_valid_stale", 64'(valid_out), 64'd0);
        step();
        check("br_req", 64'(bus.imem_req), 64'd1);
        check("br_addr", 64'(bus.imem_addr), 64'h100);
        for (int i = 0; i < 3; i++) begin
            step();
            check("br_wait_valid", 64'(valid_out), 64'd0);
        end
        step();
        check("br_valid", 64'(valid_out), 64'd1);
        check("br_pc", 64'(pc_out), 64'h104);
        check("br_inst", 64'(inst_out), 64'hDEAD_0100);

        // Exception and branch together
        quiesce_reset(1);
        bus.imem_gnt = 1'b1;
        except = 1'b1;
        br = 1'b1;
        pc_branch = 32'h80;
        #1;
        check("exc_req_redir", 64'(bus.imem_req), 64'd0);
        step();
        except = 1'b0;
        br = 1'b0;
        #1;
        check("exc_addr", 64'(bus.imem_addr), 64'h4000_0040);
        check("exc_req", 64'(bus.imem_req), 64'd1);
        step();
        step();
        check("exc_valid", 64'(valid_out), 64'd1);
        check("exc_pc", 64'(pc_out), 64'h4000_0044);
        check("exc_inst", 64'(inst_out), 64'h9EAD_0040);

        // Fetch PC wrap-around
        quiesce_reset(1);
        bus.imem_gnt = 1'b1;
        br = 1'b1;
        pc_branch = 32'hFFFF_FFFF;
        step();
        br = 1'b0;
        #1;
        check("wrap_addr_top", 64'(bus.imem_addr), 64'hFFFF_FFFC);
        step();
        check("wrap_addr_zero", 64'(bus.imem_addr), 64'h0);
        step();
        check("wrap_valid", 64'(valid_out), 64'd1);
        check("wrap_pc", 64'(pc_out), 64'h0);
        check("wrap_inst", 64'(inst_out), 64'h2152_FFFC);

        // Reset while a request is outstanding
        quiesce_reset(3);
        bus.imem_gnt = 1'b1;
        br = 1'b1;
        pc_branch = 32'h200;
        step();
        br = 1'b0;
        #1;
        check("rmid_addr", 64'(bus.imem_addr), 64'h200);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rmid_req_drop", 64'(bus.imem_req), 64'd0);
        step();
        check("rmid_late_rv", 64'(bus.imem_rvalid), 64'd1);
        check("rmid_valid_late", 64'(valid_out), 64'd0);
        step();
        check("rmid_valid", 64'(valid_out), 64'd0);
        check("rmid_req", 64'(bus.imem_req), 64'd1);
        check("rmid_addr0", 64'(bus.imem_addr), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
